// File: rtl/hdc_trigram_encoder.sv
// Trigram encoder for the HDC text classifier.
// Accepts one 7-bit character per valid/ready transfer. Each character maps
// to an item vector, which is a rotation of SEED. From the third character
// onwards the encoder binds each trigram by rotating and XORing item vectors.
// The bound trigram is added into one counter per dimension. After the last
// character, a majority threshold produces a single binary query hypervector.
//
// Handshake rule on both interfaces: a transfer happens on a rising edge where
// valid && ready. A source holds its payload stable while valid is high and
// ready is low. This block's valid outputs do not depend on the ready inputs.
module hdc_trigram_encoder #(
  parameter int          D          = 1024,
  parameter int          MAX_LENGTH = 160,
  parameter int          CW         = 8,
  parameter logic [D-1:0] SEED      = {D/32{32'h9E3779B9}},
  parameter int          STRIDE     = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [6:0]    in_char,
  input  logic          in_last,
  output logic          hv_valid,
  input  logic          hv_ready,
  output logic [D-1:0]  hv_out,
  output logic [CW-1:0] hv_ngrams
);

  localparam int PW = $clog2(MAX_LENGTH + 1);
  localparam logic [PW-1:0] POS_MAX = PW'(MAX_LENGTH);
  localparam logic [PW-1:0] POS_TRI = PW'(2);

  typedef enum logic [1:0] {
    S_ACCUM  = 2'd0,
    S_THRESH = 2'd1,
    S_OUT    = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Rotate left by r (r < D). The upper half of the doubled vector holds the rotation.
  function automatic logic [D-1:0] rotl(input logic [D-1:0] x, input int unsigned r);
    logic [2*D-1:0] w;
    w = {x, x} << r;
    return w[2*D-1:D];
  endfunction

  logic [D-1:0]  h1;
  logic [D-1:0]  h2;
  logic [PW-1:0] pos;
  logic [CW-1:0] ngrams;
  logic [CW-1:0] cnt [D];

  int unsigned   im_amt;
  logic [D-1:0]  im_in;
  logic [D-1:0]  gram;
  logic [D-1:0]  thr;
  logic          accept;
  logic          take;
  logic          bundle;
  logic          clear;

  // Item memory: the rotation amount is the character code times the stride, taken modulo D.
  always_comb begin
    im_amt = (32'(in_char) * 32'(STRIDE)) % 32'(D);
  end

  assign im_in = rotl(SEED, im_amt);
  assign gram  = rotl(h2, 2) ^ rotl(h1, 1) ^ im_in;

  assign accept = in_valid && in_ready;
  // Characters past MAX_LENGTH are accepted, but they leave history and counters untouched.
  assign take   = accept && (pos < POS_MAX);
  assign bundle = take && (pos >= POS_TRI);
  assign clear  = (state == S_OUT) && hv_ready;

  // Majority per dimension at CW+1 bits. A tie (2*cnt == ngrams) gives 0.
  always_comb begin
    thr = '0;
    for (int i = 0; i < D; i++) begin
      thr[i] = ({cnt[i], 1'b0} > {1'b0, ngrams});
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs decoded from state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    hv_valid   = 1'b0;
    case (state)
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_next = S_THRESH;
        end
      end
      S_THRESH: begin
        state_next = S_OUT;
      end
      S_OUT: begin
        hv_valid = 1'b1;
        if (hv_ready) begin
          state_next = S_ACCUM;
        end
      end
      default: begin
        state_next = S_ACCUM;
      end
    endcase
  end

  // History, position and bundling counters. They clear on reset and on the output handshake.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      h1     <= '0;
      h2     <= '0;
      pos    <= '0;
      ngrams <= '0;
      for (int i = 0; i < D; i++) begin
        cnt[i] <= '0;
      end
    end else if (take) begin
      h2  <= h1;
      h1  <= im_in;
      pos <= pos + PW'(1);
      if (bundle) begin
        ngrams <= ngrams + CW'(1);
        for (int i = 0; i < D; i++) begin
          cnt[i] <= cnt[i] + CW'(gram[i]);
        end
      end
    end
  end

  // Output registers. They load during THRESH and then hold through OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      hv_out    <= '0;
      hv_ngrams <= '0;
    end else if (state == S_THRESH) begin
      hv_out    <= thr;
      hv_ngrams <= ngrams;
    end
  end

endmodule

// File: tb/tb_hdc_trigram_encoder.sv
// Bench for hdc_trigram_encoder with D=8, STRIDE=1 and SEED=8'h01.
// Two instances share the same inputs. They differ in MAX_LENGTH: 160 and 4.
module tb_hdc_trigram_encoder;

  localparam int D  = 8;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_last;
  logic hv_ready;
  logic [6:0] in_char;

  logic          in_ready_a, hv_valid_a;
  logic [D-1:0]  hv_out_a;
  logic [CW-1:0] hv_ngrams_a;
  logic          in_ready_b, hv_valid_b;
  logic [D-1:0]  hv_out_b;
  logic [CW-1:0] hv_ngrams_b;

  always #5 clk = ~clk;

  hdc_trigram_encoder #(
    .D(D), .MAX_LENGTH(160), .CW(CW), .SEED(8'h01), .STRIDE(1)
  ) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_char(in_char), .in_last(in_last),
    .hv_valid(hv_valid_a), .hv_ready(hv_ready), .hv_out(hv_out_a), .hv_ngrams(hv_ngrams_a)
  );

  hdc_trigram_encoder #(
    .D(D), .MAX_LENGTH(4), .CW(CW), .SEED(8'h01), .STRIDE(1)
  ) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_char(in_char), .in_last(in_last),
    .hv_valid(hv_valid_b), .hv_ready(hv_ready), .hv_out(hv_out_b), .hv_ngrams(hv_ngrams_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // Each entry holds {out_a, ngrams_a, out_b, ngrams_b}.
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] x, input int r);
    int rr;
    rr = r % 8;
    return (x << rr) | (x >> (8 - rr));
  endfunction

  function automatic logic [7:0] item(input logic [6:0] c);
    return rotl8(8'h01, int'(c));
  endfunction

  // Trigrams come from the first min(len, maxl) characters. Each output bit is a strict majority vote.
  function automatic logic [15:0] model(input logic [6:0] m[$], input int maxl);
    int n;
    int ng;
    int votes [8];
    logic [7:0] g;
    logic [7:0] hv;
    n  = (m.size() < maxl) ? m.size() : maxl;
    ng = 0;
    for (int b = 0; b < 8; b++) votes[b] = 0;
    for (int k = 2; k < n; k++) begin
      g = rotl8(item(m[k-2]), 2) ^ rotl8(item(m[k-1]), 1) ^ item(m[k]);
      for (int b = 0; b < 8; b++) votes[b] += int'(g[b]);
      ng++;
    end
    for (int b = 0; b < 8; b++) hv[b] = (2 * votes[b] > ng);
    return {hv, 8'(ng)};
  endfunction

  // ---------------- driver tasks ----------------
  // Called off-edge. Holds the character until it is accepted, then drops valid.
  task automatic send_char(input logic [6:0] c, input logic last, input int gap);
    int w;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    w = 0;
    while (!in_ready_a && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready_a) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called just after the edge that accepts the last character. Walks through THRESH and OUT, with hold cycles of backpressure.
  task automatic recv(input int hold);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    // Junk traffic while busy must be ignored.
    in_valid = 1'b1;
    in_char  = 7'($urandom_range(0, 127));
    in_last  = 1'($urandom_range(0, 1));
    hv_ready = 1'b0;
    @(negedge clk);
    check("thresh_hv_valid_a", hv_valid_a, 0);
    check("thresh_in_ready_a", in_ready_a, 0);
    check("thresh_in_ready_b", in_ready_b, 0);
    @(negedge clk);
    check("out_hv_valid_a", hv_valid_a, 1);
    check("out_hv_valid_b", hv_valid_b, 1);
    check("out_in_ready_a", in_ready_a, 0);
    check("out_hv_out_a", hv_out_a, e[31:24]);
    check("out_ngrams_a", hv_ngrams_a, e[23:16]);
    check("out_hv_out_b", hv_out_b, e[15:8]);
    check("out_ngrams_b", hv_ngrams_b, e[7:0]);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_hv_valid_a", hv_valid_a, 1);
      check("hold_in_ready_a", in_ready_a, 0);
      check("hold_hv_out_a", hv_out_a, e[31:24]);
      check("hold_ngrams_b", hv_ngrams_b, e[7:0]);
    end
    hv_ready = 1'b1;
    @(negedge clk);
    hv_ready = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("post_hv_valid_a", hv_valid_a, 0);
    check("post_in_ready_a", in_ready_a, 1);
    check("post_in_ready_b", in_ready_b, 1);
  endtask

  task automatic run_msg(input logic [6:0] m[$], input logic [31:0] exp, input int hold, input int gap_max);
    exp_q.push_back(exp);
    for (int i = 0; i < m.size(); i++) begin
      send_char(m[i], (i == m.size() - 1), $urandom_range(0, gap_max));
    end
    recv(hold);
  endtask

  function automatic void str_to_q(input string s, output logic [6:0] m[$]);
    m = {};
    for (int i = 0; i < s.len(); i++) m.push_back(7'(s[i]));
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string      s;
    logic [7:0] out_a;
    logic [7:0] ng_a;
    logic [7:0] out_b;
    logic [7:0] ng_b;
  } vec_t;

  vec_t vec_q[$];

  task automatic add_vec(input string s, input logic [7:0] oa, input logic [7:0] na,
                         input logic [7:0] ob, input logic [7:0] nb);
    vec_t v;
    v.s = s; v.out_a = oa; v.ng_a = na; v.out_b = ob; v.ng_b = nb;
    vec_q.push_back(v);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [6:0] m[$];
    logic [15:0] ra;
    logic [15:0] rb;
    int len;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_char  = '0;
    hv_ready = 1'b0;

    add_vec("abc",    8'h08, 8'd1, 8'h08, 8'd1);
    add_vec("aaaa",   8'h0E, 8'd2, 8'h0E, 8'd2);
    add_vec("abcd",   8'h00, 8'd2, 8'h00, 8'd2);
    add_vec("ab",     8'h00, 8'd0, 8'h00, 8'd0);
    add_vec("a",      8'h00, 8'd0, 8'h00, 8'd0);
    add_vec("aaaaaa", 8'h0E, 8'd4, 8'h0E, 8'd2);

    repeat (3) @(negedge clk);
    check("rst_in_ready_a", in_ready_a, 1);
    check("rst_hv_valid_a", hv_valid_a, 0);
    check("rst_hv_out_a", hv_out_a, 0);
    check("rst_ngrams_a", hv_ngrams_a, 0);
    check("rst_hv_valid_b", hv_valid_b, 0);
    reset = 1'b0;
    @(negedge clk);

    // Table vectors, back to back with no idle cycles.
    foreach (vec_q[i]) begin
      str_to_q(vec_q[i].s, m);
      run_msg(m, {vec_q[i].out_a, vec_q[i].ng_a, vec_q[i].out_b, vec_q[i].ng_b}, 0, 0);
    end

    // Backpressure: outputs hold for 5 cycles while hv_ready is low.
    str_to_q("abc", m);
    run_msg(m, {8'h08, 8'd1, 8'h08, 8'd1}, 5, 0);

    // Reset in the middle of a message drops the partial message.
    send_char(7'h61, 1'b0, 0);
    send_char(7'h62, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_in_ready_a", in_ready_a, 1);
    check("midrst_hv_valid_a", hv_valid_a, 0);
    str_to_q("abc", m);
    run_msg(m, {8'h08, 8'd1, 8'h08, 8'd1}, 0, 0);

    // Reset during OUT clears the presented result.
    send_char(7'h61, 1'b0, 0);
    send_char(7'h61, 1'b0, 0);
    send_char(7'h61, 1'b1, 0);
    @(negedge clk);
    @(negedge clk);
    check("outrst_pre_hv_valid_a", hv_valid_a, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("outrst_hv_valid_a", hv_valid_a, 0);
    check("outrst_hv_out_a", hv_out_a, 0);
    check("outrst_ngrams_a", hv_ngrams_a, 0);
    check("outrst_in_ready_a", in_ready_a, 1);
    str_to_q("abcd", m);
    run_msg(m, {8'h00, 8'd2, 8'h00, 8'd2}, 0, 0);

    // Random messages checked against the reference model.
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(1, 9);
      m = {};
      for (int i = 0; i < len; i++) begin
        m.push_back(($urandom_range(0, 3) == 0) ? 7'h61 : 7'($urandom_range(0, 127)));
      end
      ra = model(m, 160);
      rb = model(m, 4);
      run_msg(m, {ra, rb}, $urandom_range(0, 3), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guards against a hang if the DUT never leaves a state.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
